// File: rtl/qpmm_sched_pkg.sv
// qpmm_sched_pkg: curve operand widths, QPMM_d0 latency and the
// response record shared by the QPMM scheduler slice.
package qpmm_sched_pkg;

    localparam int LEN_1024M_TILDE = 1026;

    typedef logic [2*LEN_1024M_TILDE-1:0] uint_Mtilde2_t;

    localparam int N          = 4;
    localparam int D          = 1;
    localparam int LAT_PE     = 1;
    localparam int latency_FA = 2;

    localparam int QPMM_LATENCY = (N + D + 1) * LAT_PE + latency_FA + 1;

    localparam int SCHED_ID_W  = 2;
    localparam int SCHED_TAG_W = 4;

    typedef struct packed {
        logic [SCHED_ID_W-1:0]  id;
        logic [SCHED_TAG_W-1:0] tag;
        uint_Mtilde2_t          z;
    } qpmm_sched_rsp_t;

endpackage

// File: rtl/qpmm_sched_if.sv
// qpmm_sched_if: requester-side operand handshakes and the
// response stream of the QPMM scheduler.
interface qpmm_sched_if #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 4
);
    import qpmm_sched_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]                      req_valid;
    logic [NREQ-1:0]                      req_ready;
    logic [NREQ-1:0][LEN_1024M_TILDE-1:0] req_a;
    logic [NREQ-1:0][LEN_1024M_TILDE-1:0] req_b;
    logic [NREQ-1:0][TAG_W-1:0]           req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    uint_Mtilde2_t    rsp_z;

    modport master (
        output req_valid, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_z
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_z
    );

endinterface

// File: rtl/qpmm_rsp_fifo.sv
// qpmm_rsp_fifo: synchronous show-ahead FIFO with a registered
// valid flag; a push into an empty FIFO is visible one cycle later.
module qpmm_rsp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          valid_q;
    logic          do_pop;

    assign do_pop = pop_i & valid_q;

    always_comb begin
        count_d = count_q;
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push_i) begin
                wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign valid_o = valid_q;
    assign rdata_o = mem_q[rd_q];
    assign count_o = count_q;

    // Credit gating upstream must make this unreachable.
    a_no_push_full: assert property (
        @(posedge clk) disable iff (!rstn)
        !(push_i && count_q == CW'(DEPTH))
    );

endmodule

// File: rtl/qpmm_sched.sv
// qpmm_sched: round-robin issue of A*B to one shared QPMM_d0 with
// credit-gated response FIFO. QPMM_SCHED_PERF_EN adds perf counters.
module qpmm_sched
    import qpmm_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int TAG_W      = 4,
    parameter int QPMM_LAT   = QPMM_LATENCY,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    qpmm_sched_if.slave                bus,
    output logic [LEN_1024M_TILDE-1:0] qpmm_a,
    output logic [LEN_1024M_TILDE-1:0] qpmm_b,
    input  uint_Mtilde2_t              qpmm_z,
    output logic                       busy
`ifdef QPMM_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_issue,
    output logic [31:0]                perf_stall
`endif
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = CW + 1;
    localparam int FW  = IDW + TAG_W + $bits(uint_Mtilde2_t);

    logic [IDW-1:0]   rr_q;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   idx;
    logic             gnt_ok;
    logic             can_issue;
    logic             exit_v;
    logic [CW-1:0]    inflight_q;
    logic [CW-1:0]    inflight_d;
    logic [CW-1:0]    fifo_cnt;
    logic             fifo_v;
    logic             pop;
    logic [FW-1:0]    fifo_rd;
    int               j;

    // Stage 0 rides with qpmm_a/b; stage QPMM_LAT lines up with qpmm_z.
    logic             meta_v_q   [QPMM_LAT+1];
    logic [IDW-1:0]   meta_id_q  [QPMM_LAT+1];
    logic [TAG_W-1:0] meta_tag_q [QPMM_LAT+1];

    assign can_issue = (SW'(inflight_q) + SW'(fifo_cnt)) < SW'(FIFO_DEPTH);

    always_comb begin
        gnt_ok = 1'b0;
        gnt_id = '0;
        idx    = '0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            idx = IDW'(j);
            if (!gnt_ok && bus.req_valid[idx]) begin
                gnt_ok = 1'b1;
                gnt_id = idx;
            end
        end
        gnt_ok = gnt_ok & can_issue & rstn;
    end

    assign bus.req_ready = gnt_ok ? (NREQ'(1) << gnt_id) : '0;
    assign exit_v        = meta_v_q[QPMM_LAT];

    always_comb begin
        inflight_d = inflight_q;
        case ({gnt_ok, exit_v})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_q       <= '0;
            inflight_q <= '0;
            qpmm_a     <= '0;
            qpmm_b     <= '0;
            for (int s = 0; s <= QPMM_LAT; s++) begin
                meta_v_q[s]   <= 1'b0;
                meta_id_q[s]  <= '0;
                meta_tag_q[s] <= '0;
            end
        end else begin
            inflight_q  <= inflight_d;
            meta_v_q[0] <= gnt_ok;
            if (gnt_ok) begin
                qpmm_a        <= bus.req_a[gnt_id];
                qpmm_b        <= bus.req_b[gnt_id];
                meta_id_q[0]  <= gnt_id;
                meta_tag_q[0] <= bus.req_tag[gnt_id];
                rr_q <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            for (int s = 1; s <= QPMM_LAT; s++) begin
                meta_v_q[s]   <= meta_v_q[s-1];
                meta_id_q[s]  <= meta_id_q[s-1];
                meta_tag_q[s] <= meta_tag_q[s-1];
            end
        end
    end

    qpmm_rsp_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (exit_v),
        .wdata_i ({meta_id_q[QPMM_LAT], meta_tag_q[QPMM_LAT], qpmm_z}),
        .pop_i   (pop),
        .valid_o (fifo_v),
        .rdata_o (fifo_rd),
        .count_o (fifo_cnt)
    );

    assign bus.rsp_valid = fifo_v & rstn;
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign {bus.rsp_id, bus.rsp_tag, bus.rsp_z} = fifo_rd;
    assign busy = rstn & ((inflight_q != '0) | fifo_v);

`ifdef QPMM_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (gnt_ok && perf_issue != '1) begin
                perf_issue <= perf_issue + 1'b1;
            end
            if (|bus.req_valid && !can_issue && perf_stall != '1) begin
                perf_stall <= perf_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qpmm_sched.sv
// tb_qpmm_sched: table-driven arbiter vectors, directed corner
// sequences and random traffic against a queue-based reference.
module tb_qpmm_sched;
    import qpmm_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int TAG_W = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int AW    = LEN_1024M_TILDE;
    localparam int ZW    = $bits(uint_Mtilde2_t);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    qpmm_sched_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();

    logic [AW-1:0] qpmm_a;
    logic [AW-1:0] qpmm_b;
    logic [ZW-1:0] qpmm_z;
    logic          busy;
`ifdef QPMM_SCHED_PERF_EN
    logic [31:0]   perf_issue;
    logic [31:0]   perf_stall;
`endif

    qpmm_sched #(
        .NREQ(NREQ), .TAG_W(TAG_W),
        .QPMM_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .qpmm_a(qpmm_a), .qpmm_b(qpmm_b),
        .qpmm_z(qpmm_z), .busy(busy)
`ifdef QPMM_SCHED_PERF_EN
        , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
    );

    // Behavioural QPMM: product of the pins, LAT cycles later, no reset.
    logic [ZW-1:0] zp [LAT];
    always @(posedge clk) begin
        zp[0] <= ZW'(qpmm_a) * ZW'(qpmm_b);
        for (int k = 1; k < LAT; k++) zp[k] <= zp[k-1];
    end
    assign qpmm_z = zp[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              id;
        logic [TAG_W-1:0] tag;
        logic [ZW-1:0]   z;
        int              due;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] exp;
    } vec_t;

    exp_t q[$];
    int   ptr_m = 0;
    int   outst = 0;
    int   nchk  = 0;
    int   nfail = 0;
    int   last_e;
    logic rst_drv = 1'b0;
    logic rnd_ops = 1'b0;
    logic [AW-1:0]    a_drv   [NREQ];
    logic [AW-1:0]    b_drv   [NREQ];
    logic [TAG_W-1:0] tag_drv [NREQ];

    task automatic chk(input string nm, input logic [ZW-1:0] got,
                       input logic [ZW-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (low bits) edge %0d",
                     nm, got[127:0], exp[127:0], cyc + 1);
        end
    endtask

    function automatic logic [AW-1:0] rnd_op();
        logic [AW-1:0] r;
        r = '0;
        r[63:0] = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) r = r << (AW - 64);
        return r;
    endfunction

    // One cycle: drive at negedge, check and advance the model before posedge.
    task automatic step(input logic [NREQ-1:0] v, input logic rr,
                        output logic [NREQ-1:0] got);
        int g;
        int e;
        logic [NREQ-1:0] er;
        logic ev;
        exp_t it;
        @(negedge clk);
        rstn = rst_drv;
        if (rnd_ops) begin
            for (int i = 0; i < NREQ; i++) begin
                a_drv[i]   = rnd_op();
                b_drv[i]   = rnd_op();
                tag_drv[i] = TAG_W'($urandom);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i]   = a_drv[i];
            bus.req_b[i]   = b_drv[i];
            bus.req_tag[i] = tag_drv[i];
        end
        bus.req_valid = v;
        bus.rsp_ready = rr;
        #1;
        e      = cyc + 1;
        last_e = e;
        got    = bus.req_ready;
        g      = -1;
        if (rstn && outst < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && v[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", got, er);
        ev = rstn && q.size() > 0 && q[0].due <= e;
        chk("rsp_valid", bus.rsp_valid, ev);
        chk("busy", busy, rstn && outst != 0);
        if (ev && bus.rsp_valid) begin
            chk("rsp_id", bus.rsp_id, q[0].id);
            chk("rsp_tag", bus.rsp_tag, q[0].tag);
            chk("rsp_z", bus.rsp_z, q[0].z);
        end
        if (!rstn) begin
            q.delete();
            ptr_m = 0;
            outst = 0;
        end else begin
            if (ev && rr) begin
                void'(q.pop_front());
                outst--;
            end
            if (g >= 0) begin
                it.id  = g;
                it.tag = tag_drv[g];
                it.z   = ZW'(a_drv[g]) * ZW'(b_drv[g]);
                it.due = e + LAT + 2;
                q.push_back(it);
                ptr_m = (g + 1) % NREQ;
                outst++;
            end
        end
    endtask

    task automatic drain();
        logic [NREQ-1:0] got;
        for (int n = 0; n < 40 && q.size() > 0; n++) step('0, 1'b1, got);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [15];
        logic [NREQ-1:0] got;
        int t_iss, first, grants, pops, seen;

        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0001};
        tbl[2]  = '{4'b1111, 4'b0010};
        tbl[3]  = '{4'b1111, 4'b0100};
        tbl[4]  = '{4'b1111, 4'b1000};
        tbl[5]  = '{4'b1111, 4'b0001};
        tbl[6]  = '{4'b0100, 4'b0100};
        tbl[7]  = '{4'b0100, 4'b0100};
        tbl[8]  = '{4'b0001, 4'b0001};
        tbl[9]  = '{4'b1001, 4'b1000};
        tbl[10] = '{4'b0000, 4'b0000};
        tbl[11] = '{4'b0110, 4'b0010};
        tbl[12] = '{4'b0110, 4'b0100};
        tbl[13] = '{4'b0011, 4'b0001};
        tbl[14] = '{4'b0011, 4'b0010};

        for (int i = 0; i < NREQ; i++) begin
            a_drv[i]   = AW'(i + 2);
            b_drv[i]   = AW'(i + 9);
            tag_drv[i] = TAG_W'(i + 1);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;

        rst_drv = 1'b0;
        repeat (3) step(4'b1111, 1'b1, got);
        rst_drv = 1'b1;
        step('0, 1'b1, got);
        chk("rst_qpmm_a", qpmm_a, 0);
        chk("rst_qpmm_b", qpmm_b, 0);

        rnd_ops = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, 1'b1, got);
            chk("arb_tbl", got, tbl[i].exp);
        end
        drain();

        rnd_ops  = 1'b0;
        a_drv[0] = AW'(3);
        b_drv[0] = AW'(5);
        tag_drv[0] = TAG_W'(7);
        step(4'b0001, 1'b1, got);
        chk("t1_grant", got, 4'b0001);
        t_iss = last_e;
        first = -1;
        for (int k = 0; k < 20 && first < 0; k++) begin
            step('0, 1'b1, got);
            if (bus.rsp_valid) begin
                first = last_e;
                chk("t1_id", bus.rsp_id, 0);
                chk("t1_tag", bus.rsp_tag, 7);
                chk("t1_z", bus.rsp_z, 15);
            end
        end
        chk("t1_latency", first, t_iss + LAT + 2);
        drain();

        rnd_ops = 1'b1;
        grants  = 0;
        for (int k = 0; k < 14; k++) begin
            step(4'b0001, 1'b0, got);
            if (got != '0) grants++;
        end
        chk("t3_issues", grants, DEPTH);
        chk("t3_blocked", got, 0);
        pops = 0;
        for (int k = 0; k < 12; k++) begin
            step('0, 1'b1, got);
            if (bus.rsp_valid) pops++;
        end
        chk("t3_pops", pops, DEPTH);
        step(4'b0001, 1'b1, got);
        chk("t3_resume", got, 4'b0001);
        drain();

        repeat (5) step(4'b0001, 1'b1, got);
        chk("t5_inflight", outst, 5);
        rst_drv = 1'b0;
        repeat (2) step(4'b0001, 1'b1, got);
        rst_drv = 1'b1;
        step('0, 1'b1, got);
        chk("t5_qpmm_a", qpmm_a, 0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            step('0, 1'b1, got);
            if (bus.rsp_valid || busy) seen++;
        end
        chk("t5_stale", seen, 0);

        for (int k = 0; k < 400; k++) begin
            step(NREQ'($urandom), ($urandom_range(0, 3) != 0), got);
        end
        drain();

`ifdef QPMM_SCHED_PERF_EN
        rst_drv = 1'b0;
        step('0, 1'b1, got);
        rst_drv = 1'b1;
        step(4'b0001, 1'b1, got);
        step(4'b0001, 1'b1, got);
        drain();
        repeat (12) step(4'b0001, 1'b0, got);
        step('0, 1'b0, got);
        chk("perf_issue", perf_issue, 10);
        chk("perf_stall", perf_stall, 4);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

endmodule
